// File: rtl/branch_pc_unit_if.sv
// branch_pc_unit_if
//   Groups the decode/branch-condition inputs, the fetch handshake and the
//   PC/status outputs of branch_pc_unit into one bundle.
//
//   Handshake semantics: fetch_req is high only while the unit waits in FETCH.
//   The address is PC, and PC is stable for as long as fetch_req is high. A
//   cycle with fetch_req=1 and fetch_ack=1 completes the fetch. exec_done
//   completes the current instruction only when the unit is in EXEC. An ack or
//   exec_done seen at any other time has no effect.
//
//   Modports:
//     master - decode/ALU-control stage plus instruction memory (drives inputs)
//     slave  - branch_pc_unit itself
//   fsm_state carries the controller state for observation:
//   0=IDLE, 1=FETCH, 2=EXEC, 3=HALT.
interface branch_pc_unit_if;
  logic        Con_beq;
  logic        Con_bne;
  logic        Con_blt;
  logic        Con_bge;
  logic        Jal;
  logic        Jalr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        exec_done;
  logic        fetch_ack;
  logic        fetch_req;
  logic [31:0] PC;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic        misalign_trap;
  logic [31:0] stat_branches;
  logic [31:0] stat_taken;
  logic [1:0]  fsm_state;

  modport master (
    output Con_beq, Con_bne, Con_blt, Con_bge, Jal, Jalr,
    output rs1_data, rs2_data, imm, exec_done, fetch_ack,
    input  fetch_req, PC, pc_plus4, branch_taken, misalign_trap,
    input  stat_branches, stat_taken, fsm_state
  );

  modport slave (
    input  Con_beq, Con_bne, Con_blt, Con_bge, Jal, Jalr,
    input  rs1_data, rs2_data, imm, exec_done, fetch_ack,
    output fetch_req, PC, pc_plus4, branch_taken, misalign_trap,
    output stat_branches, stat_taken, fsm_state
  );
endinterface

// File: rtl/branch_pc_unit.sv
// branch_pc_unit
//   Owns the architectural PC. It sequences instruction fetch with a req/ack
//   handshake and resolves the outcome of branches and jumps when the datapath
//   reports that an instruction is complete.
//
//   Ports:
//     clk   - system clock, rising edge
//     reset - asynchronous, active-high reset
//     bus   - branch_pc_unit_if.slave, which carries:
//             decode inputs (Con_*, Jal, Jalr, rs1_data, rs2_data, imm)
//             handshakes (exec_done, fetch_ack -> fetch_req)
//             outputs (PC, pc_plus4, branch_taken, misalign_trap, stat_*,
//             fsm_state)
//
//   Optional feature macro: BRANCH_STATS_EN.
//     When it is defined, saturating counters are built for resolved and taken
//     conditional branches.
//     When it is not defined, both stat ports are tied to zero.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            reset,
  branch_pc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        branch_taken_q;
  logic        trap_q;

  logic        eq, lt;
  logic        taken;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        misalign;
  logic        fetch_req;
  logic        retire;     // exec_done accepted this cycle, target aligned
  logic        trap_set;   // exec_done accepted, taken target misaligned

  assign eq = (bus.rs1_data == bus.rs2_data);
  assign lt = ($signed(bus.rs1_data) < $signed(bus.rs2_data));

  // Only the highest-priority decode input is evaluated. If a lower-priority
  // condition would be taken, that has no effect when a higher one is present.
  always_comb begin
    taken  = 1'b0;
    target = pc_q + bus.imm;
    if (bus.Jalr) begin
      taken  = 1'b1;
      target = (bus.rs1_data + bus.imm) & 32'hFFFF_FFFE;
    end else if (bus.Jal) begin
      taken  = 1'b1;
    end else if (bus.Con_beq) begin
      taken  = eq;
    end else if (bus.Con_bne) begin
      taken  = ~eq;
    end else if (bus.Con_blt) begin
      taken  = lt;
    end else if (bus.Con_bge) begin
      taken  = ~lt;
    end
  end

  assign next_pc  = taken ? target : (pc_q + 32'd4);
  assign misalign = taken & (target[1:0] != 2'b00);

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    fetch_req = 1'b0;
    retire    = 1'b0;
    trap_set  = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        fetch_req = 1'b1;
        if (bus.fetch_ack) state_d = EXEC;
      end
      EXEC: begin
        if (bus.exec_done) begin
          if (misalign) begin
            trap_set = 1'b1;
            state_d  = HALT;
          end else begin
            retire  = 1'b1;
            state_d = FETCH;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // branch_taken is reloaded every cycle, so it stays high for one cycle only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      branch_taken_q <= 1'b0;
      trap_q         <= 1'b0;
    end else begin
      branch_taken_q <= retire & taken;
      if (retire)   pc_q   <= next_pc;
      if (trap_set) trap_q <= 1'b1;
    end
  end

  assign bus.fetch_req     = fetch_req;
  assign bus.PC            = pc_q;
  assign bus.pc_plus4      = pc_q + 32'd4;
  assign bus.branch_taken  = branch_taken_q;
  assign bus.misalign_trap = trap_q;
  assign bus.fsm_state     = state_q;

`ifdef BRANCH_STATS_EN
  // A jump suppresses the Con_* strobes, so a jump is not counted as a
  // conditional branch. A misaligned taken branch counts as resolved but not
  // as taken.
  logic        is_branch;
  logic        branch_done;
  logic [31:0] stat_branches_q;
  logic [31:0] stat_taken_q;

  assign is_branch   = ~bus.Jal & ~bus.Jalr &
                       (bus.Con_beq | bus.Con_bne | bus.Con_blt | bus.Con_bge);
  assign branch_done = (retire | trap_set) & is_branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches_q <= 32'h0;
      stat_taken_q    <= 32'h0;
    end else if (branch_done) begin
      if (stat_branches_q != 32'hFFFF_FFFF)
        stat_branches_q <= stat_branches_q + 32'd1;
      if (retire && taken && (stat_taken_q != 32'hFFFF_FFFF))
        stat_taken_q <= stat_taken_q + 32'd1;
    end
  end

  assign bus.stat_branches = stat_branches_q;
  assign bus.stat_taken    = stat_taken_q;
`else
  assign bus.stat_branches = 32'h0;
  assign bus.stat_taken    = 32'h0;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;

  logic clk;
  logic reset;
  branch_pc_unit_if bus();

  branch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] ref_pc;
  logic        ref_trap;
  logic [31:0] ref_nbr;
  logic [31:0] ref_ntk;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_stat_br"}, bus.stat_branches, STATS ? ref_nbr : 32'h0);
    check({tag, "_stat_tk"}, bus.stat_taken,    STATS ? ref_ntk : 32'h0);
  endtask

  // Reference resolution computed from the architectural rules.
  // dec bits: [5]=Jalr [4]=Jal [3]=beq [2]=bne [1]=blt [0]=bge
  function automatic void ref_resolve(input logic [31:0] pc, input logic [5:0] dec,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] im,
                                      output logic [31:0] dest, output bit tk);
    longint sa, sb;
    longint unsigned sum;
    sa = $signed(a);
    sb = $signed(b);
    tk = 1'b0;
    if      (dec[5]) tk = 1'b1;
    else if (dec[4]) tk = 1'b1;
    else if (dec[3]) tk = (a == b);
    else if (dec[2]) tk = (a != b);
    else if (dec[1]) tk = (sa < sb);
    else if (dec[0]) tk = (sa >= sb);
    if (dec[5]) begin
      sum  = (longint'(a) + longint'(im)) % 64'h1_0000_0000;
      dest = 32'(sum - (sum % 2));
    end else if (tk) begin
      sum  = (longint'(pc) + longint'(im)) % 64'h1_0000_0000;
      dest = 32'(sum);
    end else begin
      sum  = (longint'(pc) + 4) % 64'h1_0000_0000;
      dest = 32'(sum);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.Con_beq = 0; bus.Con_bne = 0; bus.Con_blt = 0; bus.Con_bge = 0;
    bus.Jal = 0; bus.Jalr = 0;
    bus.rs1_data = 0; bus.rs2_data = 0; bus.imm = 0;
    bus.exec_done = 0; bus.fetch_ack = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ref_pc = 32'h0; ref_trap = 0; ref_nbr = 0; ref_ntk = 0;
    exp_q.delete();
  endtask

  task automatic wait_fetch(output bit ok);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!bus.fetch_req && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    ok = bus.fetch_req;
    if (!ok) check("fetch_timeout", 32'(bus.fetch_req), 32'h1);
  endtask

  task automatic run_instr(input logic [5:0] dec, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] im,
                           input int delay, input bit ack_noise);
    bit ok, tk, is_br, trap;
    logic [31:0] dest, exp_pc;
    wait_fetch(ok);
    if (!ok) return;
    check("pc_in_fetch", bus.PC, ref_pc);
    check("pc_plus4", bus.pc_plus4, ref_pc + 32'd4);
    bus.fetch_ack = 1;
    @(posedge clk); #1 bus.fetch_ack = 0;
    repeat (delay) begin
      bus.fetch_ack = ack_noise;
      @(posedge clk); #1;
    end
    bus.fetch_ack = 0;
    {bus.Jalr, bus.Jal, bus.Con_beq, bus.Con_bne, bus.Con_blt, bus.Con_bge} = dec;
    bus.rs1_data = a; bus.rs2_data = b; bus.imm = im;
    bus.exec_done = 1;
    @(negedge clk);
    check("fetch_req_exec", 32'(bus.fetch_req), 32'h0);
    check("bt_before", 32'(bus.branch_taken), 32'h0);
    ref_resolve(ref_pc, dec, a, b, im, dest, tk);
    trap  = tk && (dest % 4 != 0);
    is_br = !dec[5] && !dec[4] && (dec[3:0] != 0);
    if (is_br) begin
      ref_nbr++;
      if (tk && !trap) ref_ntk++;
    end
    if (!trap) exp_q.push_back(dest);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    if (trap) begin
      ref_trap = 1;
      check("pc_trap_hold", bus.PC, ref_pc);
      check("trap_flag", 32'(bus.misalign_trap), 32'h1);
      check("bt_on_trap", 32'(bus.branch_taken), 32'h0);
    end else begin
      exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check("pc_next", bus.PC, exp_pc);
      check("bt_pulse", 32'(bus.branch_taken), 32'(tk));
      check("trap_clear", 32'(bus.misalign_trap), 32'h0);
      ref_pc = exp_pc;
    end
    check_stats("instr");
    @(negedge clk);
    check("bt_drop", 32'(bus.branch_taken), 32'h0);
  endtask

  task automatic goto_pc(input logic [31:0] a);
    run_instr(6'b100000, a, 32'h0, 32'h0, 0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    logic [5:0] dec;
    logic [31:0] a, b, im;
    n_checks = 0; n_pass = 0;
    clear_inputs();
    reset = 1'b1;
    #2;
    check("rst_pc", bus.PC, 32'h0);
    check("rst_req", 32'(bus.fetch_req), 32'h0);
    check("rst_trap", 32'(bus.misalign_trap), 32'h0);
    do_reset();
    @(negedge clk);
    check("idle_req", 32'(bus.fetch_req), 32'h0);
    check("idle_state", 32'(bus.fsm_state), 32'h0);
    check_stats("rst");
    @(negedge clk);
    check("fetch_req_up", 32'(bus.fetch_req), 32'h1);

    // Plain sequential instruction
    run_instr(6'b000000, 32'h0, 32'h0, 32'h0, 0, 0);

    // beq taken / not taken
    goto_pc(32'h10);
    run_instr(6'b001000, 32'd5, 32'd5, 32'h20, 1, 1);
    goto_pc(32'h10);
    run_instr(6'b001000, 32'd5, 32'd6, 32'h20, 2, 0);

    // Signed compare, priority between blt and bge
    goto_pc(32'h40);
    run_instr(6'b000010, 32'hFFFF_FFFF, 32'h1, 32'h8, 0, 0);
    goto_pc(32'h40);
    run_instr(6'b000001, 32'hFFFF_FFFF, 32'h1, 32'h8, 0, 0);
    goto_pc(32'h40);
    run_instr(6'b000011, 32'hFFFF_FFFF, 32'h1, 32'h8, 0, 0);

    // Jalr clears bit 0
    run_instr(6'b100000, 32'h101, 32'h0, 32'h3, 0, 0);

    // Wrap-around
    goto_pc(32'hFFFF_FFFC);
    run_instr(6'b000000, 32'h0, 32'h0, 32'h0, 0, 0);

    // Randomized aligned traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0: dec = 6'b010000;
        1: dec = 6'b100000;
        2: dec = 6'b001000;
        3: dec = 6'b000100;
        4: dec = 6'b000010;
        5: dec = 6'b000001;
        6: dec = {2'b00, 4'($urandom_range(1, 15))};
        7: dec = {1'b0, 1'b1, 4'($urandom_range(0, 15))};
        default: dec = 6'b000000;
      endcase
      a = $urandom();
      a[1] = 1'b0;
      case ($urandom_range(0, 2))
        0: b = a;
        1: b = 32'($signed(a) + $signed(32'($urandom_range(0, 4)) - 32'sd2));
        default: b = $urandom();
      endcase
      im = $urandom();
      im[1:0] = 2'b00;
      if (!dec[5]) a[0] = $urandom_range(0, 1);
      run_instr(dec, a, b, im, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Reset while in FETCH with ack pending
    goto_pc(32'h80);
    wait_fetch(ok);
    bus.fetch_ack = 1;
    reset = 1;
    #1;
    check("midrst_pc", bus.PC, 32'h0);
    check("midrst_state", 32'(bus.fsm_state), 32'h0);
    check("midrst_req", 32'(bus.fetch_req), 32'h0);
    check("midrst_stat_br", bus.stat_branches, 32'h0);
    check("midrst_stat_tk", bus.stat_taken, 32'h0);
    @(posedge clk); #1;
    reset = 0;
    bus.fetch_ack = 0;
    ref_pc = 0; ref_nbr = 0; ref_ntk = 0; exp_q.delete();
    @(negedge clk);
    check("midrst_idle", 32'(bus.fsm_state), 32'h0);

    // Three branches, two taken
    run_instr(6'b001000, 32'd7, 32'd7, 32'h10, 0, 0);
    run_instr(6'b000100, 32'd7, 32'd7, 32'h10, 0, 0);
    run_instr(6'b000010, 32'd1, 32'd2, 32'h8, 0, 0);
    check("three_br", bus.stat_branches, STATS ? 32'd3 : 32'd0);
    check("two_tk", bus.stat_taken, STATS ? 32'd2 : 32'd0);

    // Misaligned Jal halts the unit
    goto_pc(32'h10);
    run_instr(6'b010000, 32'h0, 32'h0, 32'h6, 0, 0);
    for (int k = 0; k < 5; k++) begin
      bus.fetch_ack = 1; bus.exec_done = 1;
      @(negedge clk);
      check("halt_req", 32'(bus.fetch_req), 32'h0);
      check("halt_pc", bus.PC, 32'h10);
      check("halt_trap", 32'(bus.misalign_trap), 32'h1);
    end
    check("halt_state", 32'(bus.fsm_state), 32'h3);
    check("halt_plus4", bus.pc_plus4, 32'h14);
    do_reset();
    @(negedge clk);
    check("post_trap_clear", 32'(bus.misalign_trap), 32'h0);
    check("post_trap_pc", bus.PC, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
